// File: rtl/alu_share_ctrl.sv
// Purpose: round-robin share of one combinational ALU between two valid/ready requesters.
// Latency: accept in cycle N -> result valid in N+2 (N+1+MUL_LAT for mul ctrl 3'b111).
// Backpressure: result held in HOLD until res_ready_i; no new accept until the cycle after.
module alu_share_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic [2:0]  req0_ctrl_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    input  logic [2:0]  req1_ctrl_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_data_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        res_id_o
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    // Counter only has to reach MUL_LAT-1; keep at least one bit.
    localparam int          CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [2:0]  CTRL_MUL = 3'b111;
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);

    state_t        state, state_nxt;
    logic          rr;
    logic [CW-1:0] cnt;
    logic [31:0]   op_data1, op_data2;
    logic [2:0]    op_ctrl;
    logic          owner;
    logic [31:0]   res_data;
    logic          res_id;

    logic          grant0, grant1, accept;
    logic [31:0]   win_data1, win_data2;
    logic [2:0]    win_ctrl;

    // Arbitration: a lone valid requester wins; on a tie rr picks (0 -> req0).
    always_comb begin
        grant0    = req0_valid_i & (~req1_valid_i | ~rr);
        grant1    = req1_valid_i & (~req0_valid_i | rr);
        win_data1 = grant1 ? req1_data1_i : req0_data1_i;
        win_data2 = grant1 ? req1_data2_i : req0_data2_i;
        win_ctrl  = grant1 ? req1_ctrl_i  : req0_ctrl_i;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, handshake readys and ALU drive.
    always_comb begin
        state_nxt    = state;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        accept       = 1'b0;
        alu_data1_o  = '0;
        alu_data2_o  = '0;
        alu_ctrl_o   = '0;
        case (state)
            IDLE: begin
                if (!rst_i) begin
                    req0_ready_o = grant0;
                    req1_ready_o = grant1;
                    accept       = grant0 | grant1;
                end
                if (accept) state_nxt = EXEC;
            end
            EXEC: begin
                alu_data1_o = op_data1;
                alu_data2_o = op_data2;
                alu_ctrl_o  = op_ctrl;
                if (cnt == '0) state_nxt = HOLD;
            end
            HOLD: begin
                alu_data1_o = op_data1;
                alu_data2_o = op_data2;
                alu_ctrl_o  = op_ctrl;
                if (res_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, rr pointer, hold counter and result capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr       <= 1'b0;
            cnt      <= '0;
            op_data1 <= '0;
            op_data2 <= '0;
            op_ctrl  <= '0;
            owner    <= 1'b0;
            res_data <= '0;
            res_id   <= 1'b0;
        end else begin
            if (accept) begin
                op_data1 <= win_data1;
                op_data2 <= win_data2;
                op_ctrl  <= win_ctrl;
                owner    <= grant1;
                rr       <= ~grant1;
                cnt      <= (win_ctrl == CTRL_MUL) ? MUL_CNT : '0;
            end
            if (state == EXEC) begin
                if (cnt == '0) begin
                    res_data <= alu_data_i;
                    res_id   <= owner;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // HOLD is exactly the window in which a result is offered.
    assign res_valid_o = (state == HOLD);
    assign res_data_o  = res_data;
    assign res_id_o    = res_id;

endmodule
